ram_sp_clr: RTL and testbench

Parametrised single-port data RAM, successor to the fixed 256x16 data memory of the single-cycle core.
- Generalised width and depth.
- Byte-lane write enables.
- Selectable read latency: 0 (asynchronous) or 1 (registered).
- Hardware clear sequencer: zeroes every word after reset and reports Busy while doing so.

Sits between the datapath ALU/address path and the register-file write-back mux.

---
 rtl/ram_sp_clr_pkg.sv | 18 +
 rtl/ram_clr_seq.sv | 57 +++++
 rtl/ram_sp_clr.sv | 102 ++++++++++
 tb/tb_ram_sp_clr.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_clr_pkg.sv
// ram_sp_clr_pkg: shared types and helpers for the clearable single-port RAM.
// Optional parity storage is enabled by defining RAM_SP_CLR_PARITY_EN.
package ram_sp_clr_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  localparam int RD_COMB = 0;
  localparam int RD_REG  = 1;

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic f_lane_parity(input logic [7:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: walks every word address after reset, issuing a clear strobe,
// and holds busy until the last word has been written.
//
// state | meaning
// CLEAR | zeroing mem[cnt] each cycle, accesses blocked
// READY | normal user access
module ram_clr_seq
  import ram_sp_clr_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  // One bit wider than the address so the terminal compare cannot alias.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  clr_state_t      state, state_nxt;
  logic [ADDR_W:0] cnt, cnt_nxt;

  // State and clear-address registers; reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and clear strobe; no word is written during a reset cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = !rst;
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == CNT_LAST) state_nxt = READY;
      end
      READY: ;
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: parametrised single-port RAM with byte-lane writes, selectable
// read latency (0 = combinational, 1 = registered) and a post-reset clear.
// Define RAM_SP_CLR_PARITY_EN to add per-lane even parity and Par_Err.
module ram_sp_clr
  import ram_sp_clr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = RD_COMB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     Addr,
  input  logic [DATA_W/8-1:0]   Write_En,
  input  logic [DATA_W-1:0]     D,
  output logic [DATA_W-1:0]     O,
  output logic                  Busy
`ifdef RAM_SP_CLR_PARITY_EN
  ,
  output logic                  Par_Err
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_ok;

  ram_clr_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (Busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign user_ok = !Busy && !rst;
  assign rd_word = mem[Addr];

  // Storage: clear sweep has priority; user writes only land when idle.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (user_ok) begin
      for (int i = 0; i < NB; i++)
        if (Write_En[i]) mem[Addr][8*i +: 8] <= D[8*i +: 8];
    end
  end

`ifdef RAM_SP_CLR_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic          rd_err;

  // Parity bits follow the same write/clear rules as their data lanes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_addr] <= '0;
    end else if (user_ok) begin
      for (int i = 0; i < NB; i++)
        if (Write_En[i]) par_mem[Addr][i] <= f_lane_parity(D[8*i +: 8]);
    end
  end

  // Any lane whose stored parity disagrees with its data flags an error.
  always_comb begin
    rd_err = 1'b0;
    for (int i = 0; i < NB; i++)
      rd_err = rd_err | (f_lane_parity(rd_word[8*i +: 8]) ^ par_mem[Addr][i]);
  end
`endif

  if (RD_LAT == RD_REG) begin : g_rd_reg
    // Registered read, read-first on a same-address write; zero while busy.
    always_ff @(posedge clk) begin
      if (rst || Busy) O <= '0;
      else             O <= rd_word;
    end
`ifdef RAM_SP_CLR_PARITY_EN
    // Parity error flag registered alongside O.
    always_ff @(posedge clk) begin
      if (rst || Busy) Par_Err <= 1'b0;
      else             Par_Err <= rd_err;
    end
`endif
  end else begin : g_rd_comb
    // Combinational read, masked to zero while the clear runs.
    always_comb begin
      O = Busy ? '0 : rd_word;
    end
`ifdef RAM_SP_CLR_PARITY_EN
    // Parity error flag with the same combinational timing as O.
    always_comb begin
      Par_Err = Busy ? 1'b0 : rd_err;
    end
`endif
  end

endmodule

// File: tb/tb_ram_sp_clr.sv
// tb_ram_sp_clr: scoreboard bench for ram_sp_clr. Two instances share clk/rst:
// u_comb (16 words, combinational read) and u_reg (32 words, registered read).
module tb_ram_sp_clr;
  import ram_sp_clr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  a0;
  logic [1:0]  we0;
  logic [15:0] d0, o0;
  logic        busy0;
  logic [4:0]  a1;
  logic [1:0]  we1;
  logic [15:0] d1, o1;
  logic        busy1;
`ifdef RAM_SP_CLR_PARITY_EN
  logic        pe0, pe1;
`endif

  ram_sp_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(RD_COMB)) u_comb (
    .clk(clk), .rst(rst), .Addr(a0), .Write_En(we0), .D(d0), .O(o0), .Busy(busy0)
`ifdef RAM_SP_CLR_PARITY_EN
    , .Par_Err(pe0)
`endif
  );

  ram_sp_clr #(.DATA_W(16), .ADDR_W(5), .RD_LAT(RD_REG)) u_reg (
    .clk(clk), .rst(rst), .Addr(a1), .Write_En(we1), .D(d1), .O(o1), .Busy(busy1)
`ifdef RAM_SP_CLR_PARITY_EN
    , .Par_Err(pe1)
`endif
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // sel: 0 comb O, 1 reg O, 2 comb Busy, 3 reg Busy, 4/5 Par_Err
  function automatic logic [15:0] dut_val(input int sel);
    case (sel)
      0: return o0;
      1: return o1;
      2: return {15'b0, busy0};
      3: return {15'b0, busy1};
`ifdef RAM_SP_CLR_PARITY_EN
      4: return {15'b0, pe0};
      5: return {15'b0, pe1};
`endif
      default: return 16'hxxxx;
    endcase
  endfunction

  // Queue an expectation dc cycles from now, keeping the queue time-ordered.
  task automatic push(input int dc, input int sel, input logic [15:0] e, input string n);
    chk_t c;
    int   idx;
    c.cyc = cyc + dc;
    c.sel = sel;
    c.exp = e;
    c.name = n;
    idx = q.size();
    while (idx > 0 && q[idx-1].cyc > c.cyc) idx--;
    q.insert(idx, c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each falling edge, compare every expectation due this cycle.
  initial begin
    chk_t        c;
    logic [15:0] v;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        c = q.pop_front();
        v = dut_val(c.sel);
        n_checks++;
        if (c.cyc != cyc || v !== c.exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d, due %0d)",
                   c.name, v, c.exp, cyc, c.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    a0 = '0; we0 = '0; d0 = '0;
    a1 = '0; we1 = '0; d1 = '0;
    step();
    rst = 1'b0;

    // Clear after a one-cycle reset pulse, with writes attempted to the top word.
    a0 = 4'hF;  we0 = 2'b11; d0 = 16'hFFFF;
    a1 = 5'h1F; we1 = 2'b11; d1 = 16'hFFFF;
    for (int i = 0; i <= 33; i++) begin
      if (i == 16) we0 = 2'b00;
      if (i == 32) we1 = 2'b00;
      if (i <= 16) begin
        push(0, 2, 16'(i < 16), "clr_busy_c");
        push(0, 0, 16'h0000, "gate_o_c");
      end
      if (i <= 32) begin
        push(0, 3, 16'(i < 32), "clr_busy_r");
        push(0, 1, 16'h0000, "gate_o_r");
      end
      if (i == 32) push(1, 1, 16'h0000, "clr_top_r");
      step();
    end

    // Every word reads back zero.
    for (int a = 0; a < 32; a++) begin
      a0 = a[3:0];
      a1 = a[4:0];
      if (a < 16) push(0, 0, 16'h0000, "clr_rd_c");
      push(1, 1, 16'h0000, "clr_rd_r");
      step();
    end

    // Byte lanes on the combinational instance.
    a0 = 4'h5; we0 = 2'b11; d0 = 16'hABCD;
    push(0, 0, 16'h0000, "bl_old");
    step();
    we0 = 2'b01; d0 = 16'h1234;
    push(0, 0, 16'hABCD, "bl_full");
    step();
    we0 = 2'b00;
    push(0, 0, 16'hAB34, "bl_low");
    step();
    a0 = 4'h6; we0 = 2'b10; d0 = 16'h5678;
    step();
    we0 = 2'b00;
    push(0, 0, 16'h5600, "bl_high");
    step();
    a0 = 4'h5;
    push(0, 0, 16'hAB34, "bl_keep");
    step();

    // Registered read latency and read-first behaviour.
    a1 = 5'h10; we1 = 2'b11; d1 = 16'hBEEF;
    push(1, 1, 16'h0000, "lat_first");
    step();
    d1 = 16'h1111;
    push(1, 1, 16'hBEEF, "lat_rdfirst");
    step();
    we1 = 2'b00;
    push(1, 1, 16'h1111, "lat_new");
    step();
    step();

`ifdef RAM_SP_CLR_PARITY_EN
    a0 = 4'h3;
    u_comb.mem[3] = 16'h0001;
    push(0, 4, 16'h0001, "par_bad");
    step();
    a0 = 4'h4;
    push(0, 4, 16'h0000, "par_ok");
    step();
`endif

    // Reset from READY, then again in the middle of the clear sweep.
    a0 = 4'hC; we0 = 2'b11; d0 = 16'hCAFE;
    step();
    we0 = 2'b00;
    push(0, 0, 16'hCAFE, "pre_rst");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) rst = 1'b1;
      push(0, 2, 16'h0001, "mid_busy");
      step();
    end
    rst = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      push(0, 2, 16'(j < 16), "rst_busy");
      step();
    end
    for (int a = 0; a < 16; a++) begin
      a0 = a[3:0];
      push(0, 0, 16'h0000, "rerst_rd_c");
      step();
    end

    k = 0;
    while (busy1 && k < 40) begin
      step();
      k++;
    end
    n_checks++;
    if (busy1) begin
      n_errors++;
      $display("FAIL rerst_busy_r: got Busy=%b expected 0 within 40 cycles", busy1);
    end
    a1 = 5'h10;
    push(1, 1, 16'h0000, "rerst_rd_r");
    step();
    step();
    step();
    step();

    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
